// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// controller state encoding and the default operand width.
package seq_mul_pkg;

    // Default operand width in bits (legal range 2..32).
    localparam int SEQ_MUL_WIDTH_DEF = 32'sd8;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } seq_mul_state_e;

endpackage

// File: rtl/seq_mul_datapath.sv
// Shift-add datapath: operand registers, WIDTH+1-bit adder, 2*WIDTH-bit
// accumulator/shifter, iteration counter and the product register.
// Optional feature macro: SEQ_MUL_SIGNED_EN (two's-complement operation;
// operands are kept as magnitudes and the product is negated on the last
// iteration when the operand signs differ).
module seq_mul_datapath import seq_mul_pkg::*; #(
    parameter int WIDTH = SEQ_MUL_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_a,
    input  logic                 load_b,
    input  logic                 step,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 last_iter,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH:0]     addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH:0]   wide_s;
    logic [2*WIDTH-1:0] shifted_s;
    logic [2*WIDTH-1:0] result_s;
    logic [WIDTH-1:0]   mag_in_s;

`ifdef SEQ_MUL_SIGNED_EN
    logic sign_a_q, sign_a_d;
    logic sign_b_q, sign_b_d;

    // Magnitude of a two's-complement operand; the most negative value
    // maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction
`endif

    // Adder, shifter, final-result shaping and next-state of all datapath registers.
    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

`ifdef SEQ_MUL_SIGNED_EN
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        mag_in_s  = magnitude(data_in);
`else
        mag_in_s  = data_in;
`endif

        if (mplier_q[0]) begin
            addend_s = {1'b0, mcand_q};
        end else begin
            addend_s = {(WIDTH+1){1'b0}};
        end

        // Upper-half add keeps its carry; the {carry, acc} pair shifts right by one.
        sum_s     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend_s;
        wide_s    = {sum_s, acc_q[WIDTH-1:0]};
        shifted_s = (2*WIDTH)'(wide_s >> 1'b1);

`ifdef SEQ_MUL_SIGNED_EN
        if (sign_a_q ^ sign_b_q) begin
            result_s = ~shifted_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result_s = shifted_s;
        end
`else
        result_s = shifted_s;
`endif

        last_iter = (cnt_q == CNT_W'(WIDTH - 1));

        if (load_a) begin
            mcand_d   = mag_in_s;
            product_d = {(2*WIDTH){1'b0}};
`ifdef SEQ_MUL_SIGNED_EN
            sign_a_d  = data_in[WIDTH-1];
`endif
        end else if (load_b) begin
            mplier_d  = mag_in_s;
            acc_d     = {(2*WIDTH){1'b0}};
            cnt_d     = {CNT_W{1'b0}};
`ifdef SEQ_MUL_SIGNED_EN
            sign_b_d  = data_in[WIDTH-1];
`endif
        end else if (step) begin
            acc_d    = shifted_s;
            mplier_d = mplier_q >> 1'b1;
            cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_iter) begin
                product_d = result_s;
            end else begin
                product_d = product_q;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath registers; any reset aborts the multiplication in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q   <= {WIDTH{1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
`ifdef SEQ_MUL_SIGNED_EN
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
`endif
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef SEQ_MUL_SIGNED_EN
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
`endif
        end
    end

    assign product = product_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier top: controller FSM with registered
// busy/done status driving seq_mul_datapath.
// Optional feature macro: SEQ_MUL_SIGNED_EN (two's-complement operands/product,
// handled entirely inside the datapath; latency is identical).
module seq_multiplier import seq_mul_pkg::*; #(
    parameter int WIDTH = SEQ_MUL_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     data_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);

    seq_mul_state_e state_q, state_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic load_a_s, load_b_s, step_s, last_iter_s;

    // Next-state logic, datapath controls and next values of the status flags.
    always_comb begin
        state_d  = state_q;
        load_a_s = 1'b0;
        load_b_s = 1'b0;
        step_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_a_s = 1'b1;
                    state_d  = LOAD_B;
                end else begin
                    state_d  = IDLE;
                end
            end
            LOAD_B: begin
                // data_in carries B here, so start is not looked at.
                load_b_s = 1'b1;
                state_d  = CALC;
            end
            CALC: begin
                step_s = 1'b1;
                if (last_iter_s) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (start) begin
                    load_a_s = 1'b1;
                    state_d  = LOAD_B;
                end else begin
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == LOAD_B) || (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // Controller state and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    seq_mul_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_a    (load_a_s),
        .load_b    (load_b_s),
        .step      (step_s),
        .data_in   (data_in),
        .last_iter (last_iter_s),
        .product   (product)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8) with an expected-product
// scoreboard queue filled at issue time and drained when done is seen.
module tb_seq_multiplier;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [W-1:0]     data_in;
    logic [2*W-1:0]   product;
    logic             done;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .data_in (data_in),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    // Reference product of two operands as the design is configured.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MUL_SIGNED_EN
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
`else
        logic [2*W-1:0] ua;
        logic [2*W-1:0] ub;
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        return ua * ub;
`endif
    endfunction

    // Drive A with start, then B; check status right after the A-capture edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] expv);
        @(negedge clk);
        start   = 1'b1;
        data_in = a;
        @(negedge clk);
        start   = 1'b0;
        data_in = b;
        exp_q.push_back(expv);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || product !== 16'd0) begin
            n_errors++;
            $display("FAIL issue_status a=%0d b=%0d: busy=%b done=%b product=%0d, required busy=1 done=0 product=0",
                     a, b, busy, done, product);
        end
    endtask

    // Wait (bounded) for done, optionally pulsing start meanwhile; check latency and product.
    task automatic wait_done(input bit noise);
        int cycles;
        logic [2*W-1:0] expv;
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (done !== 1'b1) begin
                n_checks++;
                if (busy !== 1'b1 || product !== 16'd0) begin
                    n_errors++;
                    $display("FAIL busy_during_calc cycle=%0d: busy=%b product=%0d, required busy=1 product=0",
                             cycles, busy, product);
                end
                if (noise) begin
                    start   = 1'($urandom_range(0, 1));
                    data_in = W'($urandom);
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required done=1", done, cycles);
            void'(exp_q.pop_front());
        end else begin
            if (cycles != W + 1 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL latency: cycles=%0d busy=%b, required cycles=%0d busy=0", cycles, busy, W + 1);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_empty: product=%0d with no expected value", product);
            end else begin
                expv = exp_q.pop_front();
                if (product !== expv) begin
                    n_errors++;
                    $display("FAIL product: got %0d (0x%h), required %0d (0x%h)", product, product, expv, expv);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (product !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: product=%0d done=%b busy=%b, required all 0", product, done, busy);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        issue(8'd5, 8'd3, model(8'd5, 8'd3));
        wait_done(1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== 16'd15) begin
            n_errors++;
            $display("FAIL result_hold: done=%b busy=%b product=%0d, required done=1 busy=0 product=15",
                     done, busy, product);
        end
    endtask

    task automatic test_back_to_back();
        issue(8'd7, 8'd4, model(8'd7, 8'd4));
        wait_done(1'b0);
        issue(8'd9, 8'd6, model(8'd9, 8'd6));
        wait_done(1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom);
            issue(a, b, model(a, b));
            wait_done(1'b0);
        end
    endtask

    task automatic test_corners();
        issue(8'd255, 8'd255, model(8'd255, 8'd255));
        wait_done(1'b0);
        issue(8'd0, 8'd200, model(8'd0, 8'd200));
        wait_done(1'b0);
        issue(8'd1, 8'd1, model(8'd1, 8'd1));
        wait_done(1'b0);
    endtask

    task automatic test_start_ignored();
        issue(8'd12, 8'd10, model(8'd12, 8'd10));
        wait_done(1'b1);
    endtask

    task automatic test_reset_abort();
        issue(8'd13, 8'd11, model(8'd13, 8'd11));
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (product !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_midcalc: product=%0d done=%b busy=%b, required all 0", product, done, busy);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        reset_n = 1'b1;
        issue(8'd2, 8'd3, model(8'd2, 8'd3));
        wait_done(1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (product !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_done: product=%0d done=%b busy=%b, required all 0", product, done, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

`ifdef SEQ_MUL_SIGNED_EN
    task automatic test_signed();
        issue(8'hFB, 8'h03, 16'hFFF1);
        wait_done(1'b0);
        issue(8'h80, 8'h80, 16'd16384);
        wait_done(1'b0);
        issue(8'h7F, 8'hFF, 16'hFF81);
        wait_done(1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_corners();
        test_start_ignored();
        test_reset_abort();
`ifdef SEQ_MUL_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
